// File: rtl/snap_pkg.sv
// Shared types and constants for the snapshot capture controller.
// The DELAY state exists only when SNAP_CAPTURE_CTRL_DELAY_EN is defined.
package snap_pkg;

`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_CAPTURE,
        ST_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DONE
    } state_t;
`endif

    localparam int DONE_BIT = 31;
    localparam int CAPT_BIT = 30;
    localparam int ARM_BIT  = 29;

endpackage

// File: rtl/snap_capture_ctrl_if.sv
// Block-RAM write port driven by the snapshot capture controller.
interface snap_capture_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_data;
    logic              bram_we;

    modport master (output bram_addr, output bram_data, output bram_we);
    modport slave  (input  bram_addr, input  bram_data, input  bram_we);
endinterface

// File: rtl/snap_edge_det.sv
// Registered rising-edge detector used to turn the arm level into a one-cycle pulse.
module snap_edge_det (
    input  logic user_clk,
    input  logic user_rst_n,
    input  logic level,
    output logic pulse
);

    logic level_reg;

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            level_reg <= 1'b0;
        end else begin
            level_reg <= level;
        end
    end

    assign pulse = level & ~level_reg;

endmodule

// File: rtl/snap_capture_ctrl.sv
// Snapshot capture controller: arm, trigger, then stream valid samples into a BRAM.
// Optional post-trigger delay is enabled with the macro SNAP_CAPTURE_CTRL_DELAY_EN.
module snap_capture_ctrl
    import snap_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              trig,
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    input  logic [31:0]       delay_cnt,
`endif
    output logic [31:0]       status,
    snap_capture_ctrl_if.master bram
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg, state_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              we_reg, we_next;
    logic [31:0]       status_reg, status_next;
    logic              arm_pulse;
    logic              write_sample;
    logic              ctrl_unused;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    logic [31:0]       remain_reg, remain_next;
`endif

    assign ctrl_unused = ^ctrl[31:2];

    snap_edge_det u_arm_edge (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .level      (ctrl[0]),
        .pulse      (arm_pulse)
    );

    always_ff @(posedge user_clk) begin
        if (!user_rst_n) begin
            state_reg  <= ST_IDLE;
            count_reg  <= '0;
            addr_reg   <= '0;
            data_reg   <= '0;
            we_reg     <= 1'b0;
            status_reg <= '0;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
            remain_reg <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            addr_reg   <= addr_next;
            data_reg   <= data_next;
            we_reg     <= we_next;
            status_reg <= status_next;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
            remain_reg <= remain_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        count_next   = count_reg;
        addr_next    = addr_reg;
        data_next    = data_reg;
        we_next      = 1'b0;
        write_sample = 1'b0;
        status_next  = '0;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        remain_next  = remain_reg;
`endif

        // An arm edge overrides whatever else happens this cycle, including a trigger.
        if (arm_pulse) begin
            state_next = ST_ARMED;
            count_next = '0;
        end else begin
            case (state_reg)
                ST_ARMED: begin
                    if (din_valid && (trig || ctrl[1])) begin
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
                        if (delay_cnt == 32'd0) begin
                            write_sample = 1'b1;
                        end else begin
                            state_next  = ST_DELAY;
                            remain_next = delay_cnt;
                        end
`else
                        write_sample = 1'b1;
`endif
                    end
                end
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
                ST_DELAY: begin
                    if (din_valid) begin
                        remain_next = remain_reg - 32'd1;
                        if (remain_reg == 32'd1) begin
                            state_next = ST_CAPTURE;
                        end
                    end
                end
`endif
                ST_CAPTURE: begin
                    write_sample = din_valid;
                end
                default: begin
                end
            endcase
        end

        if (write_sample) begin
            we_next    = 1'b1;
            addr_next  = count_reg[ADDR_W-1:0];
            data_next  = din;
            count_next = count_reg + 1'b1;
            state_next = (count_next == FULL_COUNT) ? ST_DONE : ST_CAPTURE;
        end

        status_next[ADDR_W:0] = count_next;
        status_next[DONE_BIT] = (state_next == ST_DONE);
        status_next[CAPT_BIT] = (state_next == ST_CAPTURE);
        status_next[ARM_BIT]  = (state_next == ST_ARMED);
    end

    assign bram.bram_addr = addr_reg;
    assign bram.bram_data = data_reg;
    assign bram.bram_we   = we_reg;
    assign status         = status_reg;

endmodule

// File: tb/tb_snap_capture_ctrl.sv
// Directed bench for snap_capture_ctrl with a write scoreboard fed by a behavioural model.
module tb_snap_capture_ctrl;

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_DELAY = 2;
    localparam int M_CAPT  = 3;
    localparam int M_DONE  = 4;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        user_clk = 1'b0;
    logic        user_rst_n;
    logic [31:0] ctrl;
    logic [31:0] din;
    logic        din_valid;
    logic        trig;
    logic [31:0] status;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
    logic [31:0] delay_cnt;
`endif

    snap_capture_ctrl_if #(.ADDR_W(10), .DATA_W(32)) bram_if ();

    snap_capture_ctrl #(.ADDR_W(10), .DATA_W(32)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl       (ctrl),
        .din        (din),
        .din_valid  (din_valid),
        .trig       (trig),
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        .delay_cnt  (delay_cnt),
`endif
        .status     (status),
        .bram       (bram_if)
    );

    always #5 user_clk = ~user_clk;

    int  tests;
    int  fails;
    int  m_state;
    int  m_cnt;
    int  m_rem;
    bit  m_prev;
    wr_t exp_q[$];

    function automatic logic [31:0] model_status();
        logic [31:0] s;
        s = '0;
        s[10:0] = m_cnt[10:0];
        s[31] = (m_state == M_DONE);
        s[30] = (m_state == M_CAPT);
        s[29] = (m_state == M_ARMED);
        return s;
    endfunction

    task automatic check_outputs();
        logic exp_we;
        wr_t  e;
        exp_we = (exp_q.size() != 0);
        tests++;
        assert (bram_if.bram_we === exp_we) else begin
            fails++;
            $error("FAIL we: got %0b want %0b (t=%0t)", bram_if.bram_we, exp_we, $time);
        end
        if (exp_we) begin
            e = exp_q.pop_front();
            if (bram_if.bram_we === 1'b1) begin
                tests++;
                assert (bram_if.bram_addr === e.addr) else begin
                    fails++;
                    $error("FAIL addr: got %0d want %0d", bram_if.bram_addr, e.addr);
                end
                tests++;
                assert (bram_if.bram_data === e.data) else begin
                    fails++;
                    $error("FAIL data: got 0x%08h want 0x%08h", bram_if.bram_data, e.data);
                end
            end
        end
        tests++;
        assert (status === model_status()) else begin
            fails++;
            $error("FAIL status: got 0x%08h want 0x%08h (t=%0t)", status, model_status(), $time);
        end
    endtask

    // One clock of stimulus; the model predicts the write this cycle produces.
    task automatic step(input logic [31:0] c, input logic v, input logic t,
                        input logic [31:0] d, input int dly);
        bit arm;
        bit wr;
        ctrl      = c;
        din_valid = v;
        trig      = t;
        din       = d;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        delay_cnt = dly;
`endif
        arm    = c[0] && !m_prev;
        m_prev = c[0];
        wr     = 1'b0;
        if (arm) begin
            m_state = M_ARMED;
            m_cnt   = 0;
        end else begin
            case (m_state)
                M_ARMED: if (v && (t || c[1])) begin
                    if (dly == 0) wr = 1'b1;
                    else begin
                        m_state = M_DELAY;
                        m_rem   = dly;
                    end
                end
                M_DELAY: if (v) begin
                    m_rem--;
                    if (m_rem == 0) m_state = M_CAPT;
                end
                M_CAPT: wr = v;
                default: ;
            endcase
        end
        if (wr) begin
            exp_q.push_back(wr_t'{addr: m_cnt[9:0], data: d});
            m_cnt++;
            m_state = (m_cnt == 1024) ? M_DONE : M_CAPT;
        end
        @(posedge user_clk);
        #1;
        check_outputs();
    endtask

    task automatic rst_step(input logic [31:0] c, input logic v, input logic t);
        user_rst_n = 1'b0;
        ctrl       = c;
        din_valid  = v;
        trig       = t;
        din        = 32'hDEAD_BEEF;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        delay_cnt  = 0;
`endif
        m_state = M_IDLE;
        m_cnt   = 0;
        m_prev  = 1'b0;
        exp_q.delete();
        @(posedge user_clk);
        #1;
        check_outputs();
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        m_state    = M_IDLE;
        m_cnt      = 0;
        m_rem      = 0;
        m_prev     = 1'b0;
        user_rst_n = 1'b0;
        ctrl       = '0;
        din        = '0;
        din_valid  = 1'b0;
        trig       = 1'b0;
`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        delay_cnt  = '0;
`endif

        // Reset state
        for (int i = 0; i < 3; i++) rst_step(32'h0, 1'b0, 1'b0);
        user_rst_n = 1'b1;
        step(32'h0, 1'b0, 1'b0, 32'h0, 0);

        // Immediate trigger, full 1024-sample capture, then DONE holds with no wrap
        for (int i = 0; i < 1032; i++) step(32'h3, 1'b1, 1'b0, 32'h100 + m_cnt, 0);
        tests++;
        assert (status === 32'h8000_0400) else begin
            fails++;
            $error("FAIL done_status: got 0x%08h want 0x80000400", status);
        end

        // External trigger at cycle 50 after arming
        step(32'h0, 1'b1, 1'b0, 32'h0, 0);
        for (int i = 0; i <= 50; i++) begin
            step(32'h1, 1'b1, (i == 50), i, 0);
            if (i == 10) begin
                tests++;
                assert (status[29] === 1'b1) else begin
                    fails++;
                    $error("FAIL armed_bit: got %0b want 1", status[29]);
                end
            end
        end

        // din_valid toggling during capture stalls the count
        for (int i = 0; i < 8; i++) step(32'h1, (i % 2 == 0), 1'b0, 32'h200 + i, 0);

        // Re-arm at count 300
        while (m_cnt < 299) step(32'h1, 1'b1, 1'b0, 32'h300 + m_cnt, 0);
        step(32'h0, 1'b1, 1'b0, 32'h3FF, 0);
        step(32'h1, 1'b1, 1'b0, 32'h4AA, 0);
        tests++;
        assert (status === 32'h2000_0000) else begin
            fails++;
            $error("FAIL rearm_status: got 0x%08h want 0x20000000", status);
        end
        step(32'h1, 1'b1, 1'b1, 32'h777, 0);

        // Reset at count 500 aborts, trig while IDLE writes nothing
        while (m_cnt < 500) step(32'h1, 1'b1, 1'b0, 32'h900 + m_cnt, 0);
        rst_step(32'h0, 1'b1, 1'b1);
        user_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(32'h0, 1'b1, 1'b1, 32'h500 + i, 0);
        tests++;
        assert (status === 32'h0) else begin
            fails++;
            $error("FAIL idle_status: got 0x%08h want 0x0", status);
        end

        // Arm and trigger in the same cycle: arm wins
        step(32'h1, 1'b1, 1'b1, 32'h55, 0);
        step(32'h1, 1'b1, 1'b1, 32'h66, 0);
        step(32'h1, 1'b1, 1'b0, 32'h67, 0);

`ifdef SNAP_CAPTURE_CTRL_DELAY_EN
        // Post-trigger delay of 5 valid samples; delay_cnt only matters at acceptance
        step(32'h0, 1'b1, 1'b0, 32'h0, 0);
        for (int i = 0; i < 22; i++) begin
            step(32'h1, (i != 13), (i == 10), i, (i == 10) ? 5 : 99);
        end
`endif

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL queue_drain: got %0d pending want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
